// File: rtl/fq_pkg.sv
// Shared constants and types for the multi-user free-pointer queue.
package fq_pkg;

  localparam int FQ_DEPTH  = 512;
  localparam int FQ_PTR_W  = 10;
  localparam int FQ_CNT_W  = 10;
  localparam int FQ_ADDR_W = $clog2(FQ_DEPTH);

  typedef enum logic {INIT, ACTIVE} fq_state_e;

  typedef logic [FQ_ADDR_W-1:0] fq_addr_t;
  typedef logic [FQ_PTR_W-1:0]  fq_ptr_t;
  typedef logic [FQ_CNT_W-1:0]  fq_cnt_t;

  localparam fq_cnt_t  FQ_FULL_CNT = fq_cnt_t'(FQ_DEPTH);
  localparam fq_addr_t FQ_LAST_ADDR = fq_addr_t'(FQ_DEPTH - 1);

endpackage

// File: rtl/fq_ptr_ram.sv
// Pointer storage: 512x10 simple dual-port RAM with synchronous write and a
// registered read. The caller drives raddr with the address of the *next*
// head, so head always shows the current queue head. A write landing on the
// address being read on the same edge is forwarded through a bypass register
// because the RAM read returns the old contents.
module fq_ptr_ram
  import fq_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     we,
  input  fq_addr_t waddr,
  input  fq_ptr_t  wdata,
  input  fq_addr_t raddr,
  output fq_ptr_t  head
);

  fq_ptr_t mem [FQ_DEPTH];
  fq_ptr_t rd_q;
  fq_ptr_t byp_q;
  logic    byp_sel_q;
  logic    collide;

  assign collide = we && (waddr == raddr);

  // Write port.
  // NOTE: the storage array is deliberately not reset; INIT rewrites every entry, and a reset would prevent block-RAM mapping.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: one-cycle registered read of the next head address.
  always_ff @(posedge clk) begin
    rd_q <= mem[raddr];
  end

  // Write-to-head forwarding; reset selects the bypass so head reads 0 at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_sel_q <= 1'b1;
      byp_q     <= '0;
    end else begin
      byp_sel_q <= collide;
      if (collide) byp_q <= wdata;
    end
  end

  assign head = byp_sel_q ? byp_q : rd_q;

endmodule

// File: rtl/multi_user_fq.sv
// Multi-user free-pointer queue. After reset it fills itself with pointers
// 0..511 (INIT), then serves pops/pushes of free cell pointers (ACTIVE).
// Optional sticky error flags: define MULTI_USER_FQ_ERR_CHECK_EN.
module multi_user_fq
  import fq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         ptr_din,
  input  logic                FQ_wr,
  input  logic                FQ_rd,
  output logic [FQ_PTR_W-1:0] ptr_dout_s,
  output logic                ptr_fifo_empty,
  output logic                FQ_act,
  output logic [FQ_CNT_W-1:0] FQ_count
`ifdef MULTI_USER_FQ_ERR_CHECK_EN
  ,
  output logic                err_underflow,
  output logic                err_overflow
`endif
);

  fq_state_e state_q, state_d;
  fq_addr_t  init_cnt_q;
  fq_addr_t  raddr_q;
  fq_addr_t  waddr_q;
  fq_addr_t  rd_addr;
  fq_cnt_t   count_q;
  fq_ptr_t   ram_wdata;
  logic      ram_we;
  logic      do_pop;
  logic      empty;
  logic      full;
  logic      unused_din_hi;

  // Upper pointer bits carry no meaning for this queue.
  assign unused_din_hi = ^ptr_din[15:10];

  assign empty = (count_q == '0);
  assign full  = (count_q == FQ_FULL_CNT);

  // Next state and datapath controls for the current edge.
  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches); blocking '=' is correct in combinational logic.
  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    ram_wdata = ptr_din[FQ_PTR_W-1:0];
    do_pop    = 1'b0;
    unique case (state_q)
      INIT: begin
        ram_we    = 1'b1;
        ram_wdata = fq_ptr_t'(init_cnt_q);
        if (init_cnt_q == FQ_LAST_ADDR) state_d = ACTIVE;
      end
      ACTIVE: begin
        do_pop = FQ_rd && !empty;
        ram_we = FQ_wr && (!full || do_pop);
      end
      default: state_d = INIT;
    endcase
    rd_addr = do_pop ? raddr_q + fq_addr_t'(1) : raddr_q;
  end

  // State register.
  // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  // Address, init-counter and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt_q <= '0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      count_q    <= '0;
    end else begin
      if (state_q == INIT) init_cnt_q <= init_cnt_q + fq_addr_t'(1);
      if (ram_we)          waddr_q    <= waddr_q + fq_addr_t'(1);
      raddr_q <= rd_addr;
      unique case ({ram_we, do_pop})
        2'b10:   count_q <= count_q + fq_cnt_t'(1);
        2'b01:   count_q <= count_q - fq_cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  fq_ptr_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (waddr_q),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .head  (ptr_dout_s)
  );

  assign FQ_act         = (state_q == ACTIVE);
  assign FQ_count       = count_q;
  assign ptr_fifo_empty = empty;

`ifdef MULTI_USER_FQ_ERR_CHECK_EN
  // Sticky misuse flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else if (state_q == ACTIVE) begin
      if (FQ_rd && empty)           err_underflow <= 1'b1;
      if (FQ_wr && full && !do_pop) err_overflow  <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_user_fq.sv
// Self-checking bench for multi_user_fq: stimulus queues expected pop values,
// a negedge monitor compares them against ptr_dout_s on every accepted pop.
module tb_multi_user_fq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ptr_din;
  logic        FQ_wr;
  logic        FQ_rd;
  logic [9:0]  ptr_dout_s;
  logic        ptr_fifo_empty;
  logic        FQ_act;
  logic [9:0]  FQ_count;
`ifdef MULTI_USER_FQ_ERR_CHECK_EN
  logic        err_underflow;
  logic        err_overflow;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  mon_exp;

  multi_user_fq dut (
    .clk            (clk),
    .rst            (rst),
    .ptr_din        (ptr_din),
    .FQ_wr          (FQ_wr),
    .FQ_rd          (FQ_rd),
    .ptr_dout_s     (ptr_dout_s),
    .ptr_fifo_empty (ptr_fifo_empty),
    .FQ_act         (FQ_act),
    .FQ_count       (FQ_count)
`ifdef MULTI_USER_FQ_ERR_CHECK_EN
    ,
    .err_underflow  (err_underflow),
    .err_overflow   (err_overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted pop must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && FQ_act && FQ_rd && !ptr_fifo_empty) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0d, expected no pop", ptr_dout_s);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_data", 32'(ptr_dout_s), 32'(mon_exp));
      end
    end
  end

  // Release reset and follow INIT; optionally fire FQ_rd/FQ_wr at cycle 100.
  task automatic run_init(input bit inject);
    int cyc;
    cyc = 0;
    rst = 1'b0;
    while (!FQ_act && cyc < 600) begin
      if (inject && cyc == 99) begin
        FQ_rd   = 1'b1;
        FQ_wr   = 1'b1;
        ptr_din = 16'h03FF;
      end else begin
        FQ_rd = 1'b0;
        FQ_wr = 1'b0;
      end
      tick();
      cyc++;
      if (inject && cyc == 101) check("init_count_mid", 32'(FQ_count), 101);
    end
    FQ_rd = 1'b0;
    FQ_wr = 1'b0;
    check("init_cycles", 32'(cyc), 512);
    check("init_act", 32'(FQ_act), 1);
    check("init_count", 32'(FQ_count), 512);
    check("init_head", 32'(ptr_dout_s), 0);
    check("init_empty", 32'(ptr_fifo_empty), 0);
  endtask

  // Pop n times back-to-back, expecting first, first+1, ... (mod 512).
  task automatic pop_seq(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      FQ_rd = 1'b1;
      exp_q.push_back(10'((first + i) % 512));
      tick();
    end
    FQ_rd = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    FQ_rd = 1'b0;
    FQ_wr = 1'b0;
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    FQ_rd   = 1'b0;
    FQ_wr   = 1'b0;
    ptr_din = '0;
    #1;
    check("rst_act", 32'(FQ_act), 0);
    check("rst_count", 32'(FQ_count), 0);
    check("rst_empty", 32'(ptr_fifo_empty), 1);
    check("rst_head", 32'(ptr_dout_s), 0);
    tick();
    tick();

    // Init with ignored requests at cycle 100, then three consecutive pops.
    run_init(1'b1);
    pop_seq(3, 0);
    check("pop3_count", 32'(FQ_count), 509);
    check("pop3_head", 32'(ptr_dout_s), 3);

    // Drain the rest: the full 0..511 init sequence comes out in order.
    pop_seq(509, 3);
    check("drain_empty", 32'(ptr_fifo_empty), 1);
    check("drain_count", 32'(FQ_count), 0);

    // Pop while empty is ignored.
    FQ_rd = 1'b1;
    tick();
    FQ_rd = 1'b0;
    check("underpop_count", 32'(FQ_count), 0);
    check("underpop_empty", 32'(ptr_fifo_empty), 1);
`ifdef MULTI_USER_FQ_ERR_CHECK_EN
    check("err_underflow_set", 32'(err_underflow), 1);
`endif

    // Push with a pop on an empty queue: only the push happens.
    FQ_wr   = 1'b1;
    FQ_rd   = 1'b1;
    ptr_din = 16'hFC07;
    tick();
    FQ_wr = 1'b0;
    FQ_rd = 1'b0;
    check("refill_count", 32'(FQ_count), 1);
    check("refill_head", 32'(ptr_dout_s), 10'h007);
    tick();
    check("refill_hold", 32'(ptr_dout_s), 10'h007);
    FQ_rd = 1'b1;
    exp_q.push_back(10'h007);
    tick();
    FQ_rd = 1'b0;
    check("refill_pop_count", 32'(FQ_count), 0);

    // Fresh init; push alone at full is dropped.
    reset_pulse();
    run_init(1'b0);
    FQ_wr   = 1'b1;
    ptr_din = 16'd9;
    tick();
    FQ_wr = 1'b0;
    check("fullpush_count", 32'(FQ_count), 512);
    check("fullpush_head", 32'(ptr_dout_s), 0);
`ifdef MULTI_USER_FQ_ERR_CHECK_EN
    check("err_overflow_set", 32'(err_overflow), 1);
`endif

    // Push and pop together at full: both happen, 5 returns after 511 pops.
    FQ_wr   = 1'b1;
    FQ_rd   = 1'b1;
    ptr_din = 16'd5;
    exp_q.push_back(10'd0);
    tick();
    FQ_wr = 1'b0;
    FQ_rd = 1'b0;
    check("both_count", 32'(FQ_count), 512);
    check("both_head", 32'(ptr_dout_s), 1);
    pop_seq(511, 1);
    check("wrap_head", 32'(ptr_dout_s), 5);
    FQ_rd = 1'b1;
    exp_q.push_back(10'd5);
    tick();
    FQ_rd = 1'b0;
    check("wrap_count", 32'(FQ_count), 0);

    // Mid-operation reset at count 300, then a complete re-init.
    reset_pulse();
    run_init(1'b0);
    pop_seq(212, 0);
    check("pre_rst_count", 32'(FQ_count), 300);
    rst = 1'b1;
    #2;
    check("mid_rst_act", 32'(FQ_act), 0);
    check("mid_rst_count", 32'(FQ_count), 0);
    check("mid_rst_empty", 32'(ptr_fifo_empty), 1);
    check("mid_rst_head", 32'(ptr_dout_s), 0);
`ifdef MULTI_USER_FQ_ERR_CHECK_EN
    check("mid_rst_err_ovf", 32'(err_overflow), 0);
    check("mid_rst_err_unf", 32'(err_underflow), 0);
`endif
    tick();
    run_init(1'b0);
    pop_seq(3, 0);
    check("post_rst_count", 32'(FQ_count), 509);
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_user_fq.md
MULTI_USER_FQ -- requirements
Module: multi_user_fq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic is rising-edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port ptr_din, input, 16, pointer being returned; only bits [9:0] are used, bits [15:10] are ignored.
REQ-004 SHALL have port FQ_wr, input, 1, one-cycle request to push ptr_din[9:0] into the free queue.
REQ-005 SHALL have port FQ_rd, input, 1, one-cycle request to pop the head pointer.
REQ-006 SHALL have port ptr_dout_s, output, 10, show-ahead head pointer, valid whenever ptr_fifo_empty=0.
REQ-007 SHALL have port ptr_fifo_empty, output, 1, high when FQ_count==0.
REQ-008 SHALL have port FQ_act, output, 1, high once initialisation has completed.
REQ-009 SHALL have port FQ_count, output, 10, number of free pointers held (0..512).

Function
REQ-010 SHALL hold a FIFO of up to 512 free cell pointers, 10 bits wide with values 0..511.
REQ-011 SHALL run an INIT state after reset: 512 cycles pushing pointers 0,1,...,511 in order, one per cycle, while FQ_act=0.
- During INIT, FQ_rd and FQ_wr are ignored.
REQ-012 SHALL enter the ACTIVE state after INIT: FQ_act=1, FQ_count=512, ptr_dout_s=0. FQ_act stays high until the next reset.
REQ-013 SHALL, in ACTIVE, pop on a rising edge with FQ_rd=1 and FQ_count>0.
- ptr_dout_s shows the new head in the cycle after the pop edge.
- Users sample ptr_dout_s in the same cycle they assert FQ_rd.
REQ-014 SHALL, in ACTIVE, push ptr_din[9:0] at the tail on an edge with FQ_wr=1 and FQ_count<512.
REQ-015 SHALL update FQ_count on the same edge as the push/pop: +1 for push only, -1 for pop only, unchanged for both.
REQ-016 SHALL ignore a pop when FQ_count==0, even if a push occurs on the same edge; the push still proceeds.
- If the queue is empty, a pushed pointer appears on ptr_dout_s in the cycle after the push.
REQ-017 SHALL ignore a push when FQ_count==512, unless a valid pop occurs on the same edge; then both occur.
REQ-018 SHALL hold ptr_dout_s stable while there is no pop.
REQ-019 SHALL wrap the read and write addresses modulo 512.
REQ-020 SHALL NOT check pushed values for duplicates or range; callers guarantee uniqueness.

Reset
REQ-021 SHALL, on rst=1, immediately set:
- FQ_act=0, FQ_count=0, ptr_fifo_empty=1, ptr_dout_s=0;
- read/write addresses=0;
- state=INIT with the init counter=0.
REQ-022 SHALL, on rst asserted mid-operation, discard all content and restart INIT after rst deasserts.

Configuration
REQ-023 SHALL, with macro MULTI_USER_FQ_ERR_CHECK_EN defined, add output ports:
- err_underflow: sticky, set by FQ_rd while empty in ACTIVE.
- err_overflow: sticky, set by an ignored push when full.
- Both are cleared only by reset.
REQ-024 SHALL, without MULTI_USER_FQ_ERR_CHECK_EN, omit these ports and their logic; the remaining behaviour is identical.

Structure
REQ-025 SHALL take constants from a shared package fq_pkg: FQ_DEPTH=512, FQ_PTR_W=10, FQ_CNT_W=10, and the state enum {INIT, ACTIVE}.
REQ-026 SHALL store pointers in one sub-module fq_ptr_ram: 512x10 simple dual-port, synchronous write, 1-cycle read, with head prefetch into a register driving ptr_dout_s.

Verification
REQ-027 SHALL test init: release rst, wait 512 cycles. Required: FQ_act rises, FQ_count=512, ptr_dout_s=0, ptr_fifo_empty=0.
REQ-028 SHALL test pops: after init, pop 3 times in consecutive cycles, sampling each cycle. Required: values 0,1,2; FQ_count=509; ptr_dout_s=3.
REQ-029 SHALL test drain and refill: pop 512 times, then FQ_wr with ptr_din=16'hFC07 while FQ_rd=1. Required:
- after the drain, ptr_fifo_empty=1;
- after the push, FQ_count=1, ptr_dout_s=10'h007 the next cycle.
REQ-030 SHALL test simultaneous push and pop at count 512 with ptr_din=5. Required: FQ_count stays 512; the head advances to 1; pointer 5 is returned after 511 further pops.
REQ-031 SHALL test ignored requests during INIT: assert FQ_rd and FQ_wr at cycle 100. Required: no effect; init sequence still 0..511.
REQ-032 SHALL test mid-operation reset: assert rst with FQ_count=300. Required: immediate FQ_act=0, FQ_count=0; full INIT repeats. With MULTI_USER_FQ_ERR_CHECK_EN, a pop while empty sets err_underflow=1.
